regfile_16x16: RTL
==================

REGFILE_16X16 -- requirements
Module: regfile_16x16

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter NREG, default 16, number of architectural registers; address width is 4 bits.
REQ-003 Parameter R0_ZERO, default 1; when 1, register 0 always reads 0 and is never reserved.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 wb_valid  input  1  write-back request.
REQ-007 wb_addr  input  4  write-back destination register.
REQ-008 wb_data  input  DATA_W  write-back value.
REQ-009 wb_ready  output  1  write-back accept; tied to 1.
REQ-010 rsv_valid  input  1  issue stage requests reservation of a destination register.
REQ-011 rsv_addr  input  4  register to reserve.
REQ-012 rsv_ready  output  1  reservation granted this cycle; combinational.
REQ-013 regs  output  unpacked [NREG] x DATA_W  all register contents; drives the 16:1 operand select muxes directly.
REQ-014 busy  output  NREG  per-register pending-write flags.
REQ-015 pend_cnt  output  5  number of set busy bits; range 0..16.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 Write fire = wb_valid; the register at wb_addr SHALL take wb_data at the next edge, i.e. 1-cycle write latency.
REQ-018 Without bypass, regs SHALL reflect only the registered contents.
REQ-019 Write fire SHALL clear busy[wb_addr] at the same edge.
REQ-020 rsv_ready SHALL equal !busy[rsv_addr], OR a write fire to the same address in the same cycle.
REQ-021 Reserve fire = rsv_valid && rsv_ready; it SHALL set busy[rsv_addr] at the next edge.
REQ-022 When a write and a reserve hit the same address in the same cycle, the write SHALL be applied and busy SHALL end set, giving a hand-off to the new reservation.
REQ-023 When a write and a reserve hit different addresses in the same cycle, both SHALL take effect independently.
REQ-024 pend_cnt SHALL be a registered counter updated at each edge: +1 on reserve fire only, -1 on write fire to a busy register only, unchanged on both or neither; it SHALL always equal popcount(busy).
REQ-025 A write fire to a register whose busy bit is clear SHALL still write the data and SHALL set err.
REQ-026 err SHALL stay set until rst.
REQ-027 With R0_ZERO=1, writes to register 0 SHALL be discarded.
REQ-028 With R0_ZERO=1, a reserve of register 0 SHALL see rsv_ready=1, SHALL NOT set busy[0], and SHALL NOT change pend_cnt.
REQ-029 With R0_ZERO=1, regs[0] SHALL read 0.
REQ-030 With R0_ZERO=1, a write to register 0 SHALL NOT raise err.
REQ-031 rsv_valid held while not ready SHALL cause no state change; the requester keeps rsv_addr stable.

Reset
REQ-032 While rst is high at an edge, all registers, busy, pend_cnt and err SHALL become 0; write and reserve requests in that cycle SHALL be ignored.
REQ-033 Reset asserted mid-operation SHALL discard all pending reservations.
REQ-034 A write arriving in the first cycle after reset to an unreserved register SHALL set err.

Configuration
REQ-035 Macro REGFILE_WB_BYPASS_EN: when defined, regs[wb_addr] SHALL present wb_data combinationally during a write fire (write-through), so a same-cycle read sees the new value; R0_ZERO still forces regs[0]=0.
REQ-036 When REGFILE_WB_BYPASS_EN is undefined, regs SHALL be purely registered and the new value SHALL be visible one cycle after the write fire.

Structure
REQ-037 Shared package cpu_pkg SHALL hold DATA_W, NREG, reg_addr_t (4-bit) and reg_data_t (DATA_W-bit).
REQ-038 Busy vector, pend_cnt and err logic SHALL live in sub-module reg_scoreboard.
REQ-039 regfile_16x16 SHALL own the data array and the optional bypass.

Verification
REQ-040 Reset, then observe: all regs=0, busy=0, pend_cnt=0, err=0, wb_ready=1.
REQ-041 Reserve r5 -> busy[5]=1, pend_cnt=1; reserve r5 again -> rsv_ready=0, no change; write r5=16'hBEEF -> next cycle regs[5]=BEEF, busy[5]=0, pend_cnt=0.
REQ-042 Reserve r3 on the same cycle as a write to r3 (r3 busy) -> rsv_ready=1, regs[3] updated, busy[3] stays 1, pend_cnt unchanged.
REQ-043 Write r7=16'h1234 with r7 unreserved -> regs[7]=1234 next cycle, err=1; err persists until rst.
REQ-044 Write r0=16'hFFFF and reserve r0 -> regs[0]=0, busy[0]=0, err=0.
REQ-045 Reserve all r1..r15 over 15 cycles -> pend_cnt=15; assert rst mid-sequence -> everything returns to 0.
REQ-046 With REGFILE_WB_BYPASS_EN defined, write r9=16'hA5A5 -> regs[9]=A5A5 in the same cycle; with it undefined, regs[9]=A5A5 one cycle later.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: register file geometry and data/address types.
// Imported by the register file, its scoreboard and its interface.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_16x16_if.sv
// Write-back and reservation handshakes of the register file.
// master = pipeline side (issue / write-back), slave = register file.
interface regfile_16x16_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic              wb_valid;
  reg_addr_t         wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;

  logic              rsv_valid;
  reg_addr_t         rsv_addr;
  logic              rsv_ready;

  modport master (
    output wb_valid, wb_addr, wb_data,
    output rsv_valid, rsv_addr,
    input  wb_ready, rsv_ready
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  rsv_valid, rsv_addr,
    output wb_ready, rsv_ready
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy bits, pending count, sticky error.
// A same-address write+reserve hands the register to the new owner.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG    = cpu_pkg::NREG,
  parameter int R0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  reg_addr_t       wb_addr,
  input  logic            rsv_valid,
  input  reg_addr_t       rsv_addr,
  output logic            rsv_ready,
  output logic [NREG-1:0] busy,
  output logic [4:0]      pend_cnt,
  output logic            err
);

  logic            wb_r0;
  logic            rsv_r0;
  logic            wr_fire;
  logic            wr_hit;
  logic            rsv_fire;
  logic [NREG-1:0] busy_nxt;

  // Grant, fire qualification and next busy vector.
  always_comb begin
    wb_r0     = (R0_ZERO != 0) && (wb_addr == '0);
    rsv_r0    = (R0_ZERO != 0) && (rsv_addr == '0);
    wr_fire   = wb_valid && !wb_r0;
    wr_hit    = wr_fire && busy[wb_addr];
    rsv_ready = !busy[rsv_addr] ||
                (wb_valid && (wb_addr == rsv_addr));
    rsv_fire  = rsv_valid && rsv_ready && !rsv_r0;
    busy_nxt  = busy;
    if (wr_fire)
      busy_nxt[wb_addr] = 1'b0;
    if (rsv_fire)
      busy_nxt[rsv_addr] = 1'b1;
  end

  // Busy, count and sticky error; the count tracks popcount(busy).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
      err      <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (rsv_fire && !wr_hit)
        pend_cnt <= pend_cnt + 5'd1;
      else if (!rsv_fire && wr_hit)
        pend_cnt <= pend_cnt - 5'd1;
      if (wr_fire && !busy[wb_addr])
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_16x16.sv
// 16x16 register file with reservation scoreboard.
// Define REGFILE_WB_BYPASS_EN for same-cycle write-through on regs.
module regfile_16x16
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int NREG    = cpu_pkg::NREG,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  regfile_16x16_if.slave    bus,
  output logic [DATA_W-1:0] regs [NREG],
  output logic [NREG-1:0]   busy,
  output logic [4:0]        pend_cnt,
  output logic              err
);

  logic [DATA_W-1:0] mem [NREG];
  logic              wr_keep;

  assign bus.wb_ready = 1'b1;
  assign wr_keep = bus.wb_valid &&
                   !((R0_ZERO != 0) && (bus.wb_addr == '0));

  reg_scoreboard #(
    .NREG    (NREG),
    .R0_ZERO (R0_ZERO)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (bus.wb_valid),
    .wb_addr   (bus.wb_addr),
    .rsv_valid (bus.rsv_valid),
    .rsv_addr  (bus.rsv_addr),
    .rsv_ready (bus.rsv_ready),
    .busy      (busy),
    .pend_cnt  (pend_cnt),
    .err       (err)
  );

  // Data array: one write port, r0 writes dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (wr_keep) begin
      mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Read view: registered array, optional write-through, r0 forced.
  always_comb begin
    regs = mem;
`ifdef REGFILE_WB_BYPASS_EN
    if (wr_keep)
      regs[bus.wb_addr] = bus.wb_data;
`else
`endif
    if (R0_ZERO != 0)
      regs[0] = '0;
  end

endmodule
